knn_sort_ctrl: RTL

Sequencing controller for the KNN distance sorter. Collects N (distance, type) pairs from a serial valid/ready stream into a holding register bank, drives that bank into the combinational odd-even transposition sorter, waits a fixed settle time, captures the sorted arrays, and streams the K nearest entries out in ascending-distance order. It sits between the distance-computation stage and the classification/vote stage.

---
 rtl/knn_sort_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/knn_sort_ctrl.sv
// Sequencing controller for the KNN sorter: loads N pairs into a holding bank,
// lets the combinational sorter settle, captures the K nearest and streams them out.
module knn_sort_ctrl #(
  parameter int N      = 8,
  parameter int W      = 16,
  parameter int K      = 3,
  parameter int SETTLE = 2,
  localparam int RW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_distance,
  input  logic [W-1:0]          in_type,
  output logic [0:N-1][W-1:0]   srt_dist,
  output logic [0:N-1][W-1:0]   srt_type,
  input  logic [0:N-1][W-1:0]   srt_dist_sorted,
  input  logic [0:N-1][W-1:0]   srt_type_sorted,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_distance,
  output logic [W-1:0]          out_type,
  output logic [RW-1:0]         out_rank,
  output logic                  out_last,
  output logic                  busy
);

  localparam int LW = $clog2(N);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_EMIT} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        load_cnt_q, load_cnt_d;
  logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [RW-1:0]        emit_cnt_q, emit_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [0:N-1][W-1:0]  bank_dist_q, bank_dist_d;
  logic [0:N-1][W-1:0]  bank_type_q, bank_type_d;
  logic [0:K-1][W-1:0]  res_dist_q, res_dist_d;
  logic [0:K-1][W-1:0]  res_type_q, res_type_d;

  // Only the first K sorted entries are consumed; the rest are intentionally ignored.
  logic unused_sorted;
  assign unused_sorted = ^{srt_dist_sorted, srt_type_sorted};

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    settle_cnt_d = settle_cnt_q;
    emit_cnt_d   = emit_cnt_q;
    out_valid_d  = out_valid_q;
    bank_dist_d  = bank_dist_q;
    bank_type_d  = bank_type_q;
    res_dist_d   = res_dist_q;
    res_type_d   = res_type_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          bank_dist_d[load_cnt_q] = in_distance;
          bank_type_d[load_cnt_q] = in_type;
          if (load_cnt_q == LW'(N-1)) begin
            state_d      = S_SETTLE;
            load_cnt_d   = '0;
            settle_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + LW'(1);
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE-1)) begin
          state_d      = S_CAPTURE;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      S_CAPTURE: begin
        for (int k = 0; k < K; k++) begin
          res_dist_d[k] = srt_dist_sorted[k];
          res_type_d[k] = srt_type_sorted[k];
        end
        emit_cnt_d  = '0;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (emit_cnt_q == RW'(K-1)) begin
            state_d     = S_LOAD;
            out_valid_d = 1'b0;
            emit_cnt_d  = '0;
            load_cnt_d  = '0;
          end else begin
            emit_cnt_d = emit_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Abort wins over any same-cycle handshake: the pair is dropped, the entry not consumed.
    if (flush) begin
      state_d      = S_LOAD;
      load_cnt_d   = '0;
      settle_cnt_d = '0;
      emit_cnt_d   = '0;
      out_valid_d  = 1'b0;
      bank_dist_d  = bank_dist_q;
      bank_type_d  = bank_type_q;
      res_dist_d   = res_dist_q;
      res_type_d   = res_type_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      load_cnt_q   <= '0;
      settle_cnt_q <= '0;
      emit_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      bank_dist_q  <= '0;
      bank_type_q  <= '0;
      res_dist_q   <= '0;
      res_type_q   <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      emit_cnt_q   <= emit_cnt_d;
      out_valid_q  <= out_valid_d;
      bank_dist_q  <= bank_dist_d;
      bank_type_q  <= bank_type_d;
      res_dist_q   <= res_dist_d;
      res_type_q   <= res_type_d;
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign busy         = (state_q != S_LOAD);
  assign srt_dist     = bank_dist_q;
  assign srt_type     = bank_type_q;
  assign out_valid    = out_valid_q;
  assign out_distance = res_dist_q[emit_cnt_q];
  assign out_type     = res_type_q[emit_cnt_q];
  assign out_rank     = emit_cnt_q;
  assign out_last     = out_valid_q && (emit_cnt_q == RW'(K-1));

endmodule
